// File: rtl/button_pkg.sv
// Shared definitions for the button event block: channel FSM encoding and the
// counter-width check used at elaboration.
package button_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPress = 2'd1,
    StHold  = 2'd2
  } btn_state_e;

  // True when a CNT_WIDTH-bit counter can hold max(long, repeat) - 1.
  function automatic bit cnt_width_ok(input int unsigned long_cycles,
                                      input int unsigned repeat_cycles,
                                      input int unsigned cnt_width);
    longint unsigned max_m1;
    max_m1 = longint'(long_cycles > repeat_cycles ? long_cycles : repeat_cycles) - 64'd1;
    if (cnt_width >= 64) return 1'b1;
    return (max_m1 >> cnt_width) == 64'd0;
  endfunction

endpackage

// File: rtl/button_event_ch.sv
// One button channel: level stage, IDLE/PRESS/HOLD FSM, hold counter and
// registered single-cycle event pulses.
module button_event_ch
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_WIDTH     = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  output logic rel,
  output logic long_press,
  output logic rpt,
  output logic held
);

  localparam logic [CNT_WIDTH-1:0] LongLast  = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RptLast   = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam bit                   RepeatEn  = (REPEAT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

  btn_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 a_q, a_d;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 long_q, long_d;
  logic                 rpt_q, rpt_d;
  logic                 held_q, held_d;

  always_comb begin
    a_d     = ACTIVE_LOW ? ~btn_in : btn_in;
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (a_q) begin
          state_d = StPress;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StPress: begin
        // Release is checked first so it wins over a coinciding threshold.
        if (!a_q) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else if (cnt_q == LongLast) begin
          state_d = StHold;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (!a_q) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else if (RepeatEn && cnt_q == RptLast) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end else if (RepeatEn) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
    end
  end

  assign press      = press_q;
  assign rel        = rel_q;
  assign long_press = long_q;
  assign rpt        = rpt_q;
  assign held       = held_q;

endmodule

// File: rtl/button_event.sv
// Turns debounced button levels into press/release/long-press/repeat pulses,
// one independent channel per button.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_WIDTH     = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] rel,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] rpt,
  output logic [WIDTH-1:0] held
);

  if (LONG_CYCLES < 1) begin : g_bad_long
    $fatal(1, "button_event: LONG_CYCLES must be at least 1");
  end
  if (!cnt_width_ok(LONG_CYCLES, REPEAT_CYCLES, CNT_WIDTH)) begin : g_bad_cnt
    $fatal(1, "button_event: CNT_WIDTH too small for LONG_CYCLES/REPEAT_CYCLES");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_event_ch #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in[i]),
      .press     (press[i]),
      .rel       (rel[i]),
      .long_press(long_press[i]),
      .rpt       (rpt[i]),
      .held      (held[i])
    );
  end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench: stimulus queues expected events (cycle, dut, channel, kind),
// a negedge monitor matches every observed pulse/held edge against the queue.
module tb_button_event;

  localparam int KPress = 0, KRel = 1, KLong = 2, KRpt = 3, KHeldRise = 4, KHeldFall = 5;

  typedef struct {
    int cyc;
    int dut;
    int ch;
    int kind;
  } ev_t;

  ev_t  exp_q[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] btn_a = 2'b11, btn_b = 2'b11;
  logic [1:0] press_a, rel_a, long_a, rpt_a, held_a;
  logic [1:0] press_b, rel_b, long_b, rpt_b, held_b;
  logic [1:0] prev_held [2] = '{2'b00, 2'b00};
  int   ecount = -1;
  int   base = 0;
  int   n_cmp = 0, n_bad = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  // dut 0: repeat enabled; dut 1: repeat disabled
  button_event #(
    .WIDTH(2), .ACTIVE_LOW(1'b1), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_WIDTH(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_a), .press(press_a), .rel(rel_a),
    .long_press(long_a), .rpt(rpt_a), .held(held_a)
  );

  button_event #(
    .WIDTH(2), .ACTIVE_LOW(1'b1), .LONG_CYCLES(8), .REPEAT_CYCLES(0), .CNT_WIDTH(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_b), .press(press_b), .rel(rel_b),
    .long_press(long_b), .rpt(rpt_b), .held(held_b)
  );

  function automatic string kname(input int k);
    case (k)
      KPress:    return "press";
      KRel:      return "rel";
      KLong:     return "long_press";
      KRpt:      return "rpt";
      KHeldRise: return "held_rise";
      default:   return "held_fall";
    endcase
  endfunction

  task automatic expect_ev(input int c, input int d, input int ch, input int k);
    ev_t e;
    e.cyc = base + c; e.dut = d; e.ch = ch; e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input int lab, input int d, input int ch, input int k);
    int idx;
    idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].cyc == lab && exp_q[i].dut == d &&
                           exp_q[i].ch == ch && exp_q[i].kind == k) idx = i;
    n_cmp++;
    if (idx >= 0) begin
      exp_q.delete(idx);
    end else begin
      n_bad++;
      $display("FAIL unexpected_%s dut%0d ch%0d: seen at cycle %0d (rel %0d), not expected",
               kname(k), d, ch, lab, lab - base);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int lab;
      logic [3:0] p;
      logic h;
      lab = ecount + 1;
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (d == 0) begin
            p = {rpt_a[ch], long_a[ch], rel_a[ch], press_a[ch]};
            h = held_a[ch];
          end else begin
            p = {rpt_b[ch], long_b[ch], rel_b[ch], press_b[ch]};
            h = held_b[ch];
          end
          if (p != 4'b0000) begin
            n_cmp++;
            if ($countones(p) > 1) begin
              n_bad++;
              $display("FAIL onehot dut%0d ch%0d cycle %0d: pulses %b, at most one allowed",
                       d, ch, lab - base, p);
            end
          end
          for (int k = 0; k < 4; k++) if (p[k]) match_ev(lab, d, ch, k);
          if (h && !prev_held[d][ch]) match_ev(lab, d, ch, KHeldRise);
          if (!h && prev_held[d][ch]) match_ev(lab, d, ch, KHeldFall);
          prev_held[d][ch] = h;
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= lab) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_%s dut%0d ch%0d: not observed, expected at cycle %0d (rel %0d)",
                   kname(exp_q[i].kind), exp_q[i].dut, exp_q[i].ch, exp_q[i].cyc,
                   exp_q[i].cyc - base);
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic idle(input int n);
    btn_a = 2'b11;
    btn_b = 2'b11;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with both buttons released
    rst = 1'b1;
    btn_a = 2'b11;
    btn_b = 2'b11;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs_a", int'({press_a, rel_a, long_a, rpt_a, held_a}), 0);
    chk("reset_outputs_b", int'({press_b, rel_b, long_b, rpt_b, held_b}), 0);
    rst = 1'b0;
    idle(6);
    chk("post_reset_held", int'({held_a, held_b}), 0);

    // Short press: low for cycles 0..4
    base = ecount + 1;
    expect_ev(2, 0, 0, KPress); expect_ev(2, 0, 0, KHeldRise);
    expect_ev(7, 0, 0, KRel);   expect_ev(7, 0, 0, KHeldFall);
    for (int k = 0; k < 12; k++) begin
      btn_a[0] = !(k <= 4);
      @(negedge clk);
    end

    // Long hold with repeats; release coincides with a repeat threshold
    base = ecount + 1;
    expect_ev(2, 0, 0, KPress); expect_ev(2, 0, 0, KHeldRise);
    expect_ev(10, 0, 0, KLong);
    expect_ev(14, 0, 0, KRpt);  expect_ev(18, 0, 0, KRpt);
    expect_ev(22, 0, 0, KRel);  expect_ev(22, 0, 0, KHeldFall);
    for (int k = 0; k < 28; k++) begin
      btn_a[0] = !(k <= 19);
      @(negedge clk);
    end

    // Release lands on the long-press threshold cycle
    base = ecount + 1;
    expect_ev(2, 0, 0, KPress); expect_ev(2, 0, 0, KHeldRise);
    expect_ev(10, 0, 0, KRel);  expect_ev(10, 0, 0, KHeldFall);
    for (int k = 0; k < 16; k++) begin
      btn_a[0] = !(k <= 7);
      @(negedge clk);
    end

    // Reset mid-hold: no rel, fresh press after reset
    base = ecount + 1;
    expect_ev(2, 0, 0, KPress);  expect_ev(2, 0, 0, KHeldRise);
    expect_ev(10, 0, 0, KLong);  expect_ev(13, 0, 0, KHeldFall);
    expect_ev(16, 0, 0, KPress); expect_ev(16, 0, 0, KHeldRise);
    expect_ev(24, 0, 0, KLong);
    expect_ev(28, 0, 0, KRel);   expect_ev(28, 0, 0, KHeldFall);
    for (int k = 0; k < 34; k++) begin
      btn_a[0] = !(k <= 25);
      rst = (k == 12 || k == 13);
      @(negedge clk);
    end
    rst = 1'b0;

    // Two channels, 3 cycles apart, repeat disabled
    base = ecount + 1;
    expect_ev(2, 1, 0, KPress);  expect_ev(2, 1, 0, KHeldRise);
    expect_ev(10, 1, 0, KLong);
    expect_ev(32, 1, 0, KRel);   expect_ev(32, 1, 0, KHeldFall);
    expect_ev(5, 1, 1, KPress);  expect_ev(5, 1, 1, KHeldRise);
    expect_ev(13, 1, 1, KLong);
    expect_ev(35, 1, 1, KRel);   expect_ev(35, 1, 1, KHeldFall);
    for (int k = 0; k < 42; k++) begin
      btn_b[0] = !(k <= 29);
      btn_b[1] = !(k >= 3 && k <= 32);
      @(negedge clk);
    end

    idle(8);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
